// File: rtl/qspi_flash_responder.sv
// QSPI flash target for the ROM QSPI wrapper: decodes WREN/WRSR/RDID/EB frames
// and serves bytes from an internal array; the SPI clock is clk itself.
module qspi_flash_responder #(
  parameter int unsigned MEM_AW    = 10,
  parameter logic [7:0]  DEV_ID    = 8'h17,
  parameter              INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              CS,
  inout  wire  [3:0]        DQio,
  input  logic              bd_we,
  input  logic [MEM_AW-1:0] bd_addr,
  input  logic [7:0]        bd_data,
  output logic              qe,
  output logic              wel,
  output logic              cmd_err
);

  localparam int unsigned DEPTH   = 1 << MEM_AW;
  localparam logic [7:0]  OP_WREN = 8'h06;
  localparam logic [7:0]  OP_WRSR = 8'h01;
  localparam logic [7:0]  OP_RDID = 8'hAB;
  localparam logic [7:0]  OP_QRD  = 8'hEB;

  typedef enum logic [3:0] {
    S_SYNC, S_IDLE, S_CMD, S_IGNORE, S_WRSR, S_DUMMY_S, S_ID_OUT,
    S_ADDR, S_MODE, S_DUMMY, S_DATA
  } state_t;

  state_t            state, state_n;
  logic [4:0]        cnt, cnt_n;
  logic [6:0]        op_sr, op_sr_n;
  logic [9:0]        wsr, wsr_n;
  logic [MEM_AW-1:0] addr, addr_n;
  logic [7:0]        id_sr, id_sr_n;
  logic              half, half_n;
  logic [3:0]        dout, dout_n;
  logic [3:0]        oe, oe_n;
  logic              qe_n, wel_n, err_n;

  logic [7:0]        mem [0:DEPTH-1];
  logic [3:0]        din;
  logic [7:0]        opcode;
  logic [7:0]        rd_byte;

  assign din     = DQio;
  assign opcode  = {op_sr, din[0]};
  assign rd_byte = mem[addr];

  for (genvar i = 0; i < 4; i++) begin : g_dq
    assign DQio[i] = oe[i] ? dout[i] : 1'bz;
  end

  // Backdoor preload port; the link owns the array while CS is low
  always_ff @(posedge clk) begin
    if (bd_we && CS) mem[bd_addr] <= bd_data;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state   <= S_SYNC;
      cnt     <= '0;
      op_sr   <= '0;
      wsr     <= '0;
      addr    <= '0;
      id_sr   <= '0;
      half    <= 1'b0;
      dout    <= '0;
      oe      <= '0;
      qe      <= 1'b0;
      wel     <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      op_sr   <= op_sr_n;
      wsr     <= wsr_n;
      addr    <= addr_n;
      id_sr   <= id_sr_n;
      half    <= half_n;
      dout    <= dout_n;
      oe      <= oe_n;
      qe      <= qe_n;
      wel     <= wel_n;
      cmd_err <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_sr_n = op_sr;
    wsr_n   = wsr;
    addr_n  = addr;
    id_sr_n = id_sr;
    half_n  = half;
    dout_n  = dout;
    oe_n    = oe;
    qe_n    = qe;
    wel_n   = wel;
    err_n   = cmd_err;

    // CS high ends every frame; the only point a WRSR can take effect
    if (CS) begin
      state_n = S_IDLE;
      oe_n    = '0;
      if (state == S_WRSR && cnt == 5'd16 && wel) begin
        qe_n  = wsr[9];
        wel_n = 1'b0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          op_sr_n = {op_sr[5:0], din[0]};
          cnt_n   = 5'd1;
          state_n = S_CMD;
        end
        S_CMD: begin
          op_sr_n = {op_sr[5:0], din[0]};
          cnt_n   = 5'(cnt + 5'd1);
          if (cnt == 5'd7) begin
            cnt_n = '0;
            case (opcode)
              OP_WREN: begin
                wel_n   = 1'b1;
                err_n   = 1'b0;
                state_n = S_IGNORE;
              end
              OP_WRSR: state_n = S_WRSR;
              OP_RDID: state_n = S_DUMMY_S;
              OP_QRD: begin
                if (qe) state_n = S_ADDR;
                else begin
                  err_n   = 1'b1;
                  state_n = S_IGNORE;
                end
              end
              default: begin
                err_n   = 1'b1;
                state_n = S_IGNORE;
              end
            endcase
          end
        end
        S_WRSR: begin
          // Only the bit that lands in config[1] is kept; count saturates to flag overrun
          wsr_n = {wsr[8:0], din[0]};
          if (cnt != 5'd17) cnt_n = 5'(cnt + 5'd1);
        end
        S_DUMMY_S: begin
          cnt_n = 5'(cnt + 5'd1);
          if (cnt == 5'd23) begin
            state_n = S_ID_OUT;
            dout_n  = {2'b00, DEV_ID[7], 1'b0};
            oe_n    = 4'b0010;
            id_sr_n = {DEV_ID[6:0], DEV_ID[7]};
          end
        end
        S_ID_OUT: begin
          dout_n[1] = id_sr[7];
          id_sr_n   = {id_sr[6:0], id_sr[7]};
        end
        S_ADDR: begin
          addr_n = MEM_AW'({addr, din});
          cnt_n  = 5'(cnt + 5'd1);
          if (cnt == 5'd5) begin
            cnt_n   = '0;
            state_n = S_MODE;
          end
        end
        S_MODE: begin
          cnt_n = 5'(cnt + 5'd1);
          if (cnt == 5'd1) begin
            cnt_n   = '0;
            state_n = S_DUMMY;
          end
        end
        S_DUMMY: begin
          cnt_n = 5'(cnt + 5'd1);
          if (cnt == 5'd3) begin
            state_n = S_DATA;
            dout_n  = rd_byte[7:4];
            oe_n    = 4'b1111;
            half_n  = 1'b0;
          end
        end
        S_DATA: begin
          if (!half) begin
            dout_n = rd_byte[3:0];
            half_n = 1'b1;
            addr_n = MEM_AW'(addr + MEM_AW'(1));
          end else begin
            dout_n = rd_byte[7:4];
            half_n = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Self-checking bench for qspi_flash_responder: register frames from a table,
// read streams checked through an expected-value queue. Released lines read 1.
module tb_qspi_flash_responder;

  localparam int unsigned AW = 10;
  localparam logic [7:0]  ID = 8'h17;

  logic          clk = 1'b0;
  logic          RESET = 1'b1;
  logic          CS = 1'b1;
  logic          host_oe = 1'b0;
  logic [3:0]    host_dq = 4'hF;
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [7:0]    bd_data = '0;
  logic          qe, wel, cmd_err;
  wire  [3:0]    dq;

  int checks = 0;
  int failures = 0;
  logic [3:0] sbq[$];

  assign dq = host_oe ? host_dq : 4'bzzzz;
  pullup (dq[0]);
  pullup (dq[1]);
  pullup (dq[2]);
  pullup (dq[3]);

  always #5 clk = ~clk;

  qspi_flash_responder #(.MEM_AW(AW), .DEV_ID(8'h17), .INIT_FILE("")) dut (
    .clk(clk), .RESET(RESET), .CS(CS), .DQio(dq),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_data(bd_data),
    .qe(qe), .wel(wel), .cmd_err(cmd_err)
  );

  typedef struct {
    string       name;
    logic [7:0]  op;
    int          nbits;
    logic [15:0] word;
    logic        eqe;
    logic        ewel;
    logic        eerr;
  } frame_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    CS = 1'b0;
    host_oe = 1'b1;
    host_dq = {3'b111, b};
  endtask

  task automatic send_nib(input logic [3:0] n);
    @(negedge clk);
    CS = 1'b0;
    host_oe = 1'b1;
    host_dq = n;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic release_bus();
    @(posedge clk);
    #1 host_oe = 1'b0;
  endtask

  task automatic end_frame();
    @(negedge clk);
    CS = 1'b1;
    host_oe = 1'b0;
    @(negedge clk);
  endtask

  task automatic eb_header(input logic [23:0] a);
    send_byte(8'hEB);
    for (int i = 5; i >= 0; i--) send_nib(a[i*4 +: 4]);
    for (int i = 0; i < 6; i++) send_nib(4'h0);
    release_bus();
  endtask

  task automatic bd_write(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_we = 1'b1;
    bd_addr = a;
    bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic sb_drain(input string name, input int n);
    logic [3:0] e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s: queue empty, got %h", name, dq);
      end else begin
        e = sbq.pop_front();
        check(name, 32'(dq), 32'(e));
      end
    end
  endtask

  task automatic check_flags(input string name, input logic eq, input logic ew, input logic ee);
    check({name, ".qe"}, 32'(qe), 32'(eq));
    check({name, ".wel"}, 32'(wel), 32'(ew));
    check({name, ".cmd_err"}, 32'(cmd_err), 32'(ee));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    frame_t tbl[12];
    logic [31:0] word;
    tbl[0]  = '{"wrsr_no_wren", 8'h01, 16, 16'h0200, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{"wren",         8'h06,  0, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{"wrsr_12b",     8'h01, 12, 16'h0200, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{"wrsr_17b",     8'h01, 17, 16'h0200, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{"wrsr_qe_on",   8'h01, 16, 16'h0200, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{"op_9f",        8'h9F,  0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{"wren_clr",     8'h06,  0, 16'h0000, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{"wrsr_qe_off",  8'h01, 16, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{"eb_qe0",       8'hEB,  0, 16'h0000, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{"wren2",        8'h06,  0, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{"wrsr_qe_on2",  8'h01, 16, 16'h0200, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{"wren_extra",   8'h06,  8, 16'hFF00, 1'b1, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    RESET = 1'b0;
    @(negedge clk);
    check_flags("reset", 1'b0, 1'b0, 1'b0);
    check("reset.dq", 32'(dq), 32'hF);

    for (int t = 0; t < 12; t++) begin
      send_byte(tbl[t].op);
      for (int i = 0; i < tbl[t].nbits; i++)
        send_bit((i < 16) ? tbl[t].word[15-i] : 1'b1);
      end_frame();
      check_flags(tbl[t].name, tbl[t].eqe, tbl[t].ewel, tbl[t].eerr);
    end

    // Quad read of four preloaded bytes
    bd_write(10'h004, 8'h04);
    bd_write(10'h005, 8'h05);
    bd_write(10'h006, 8'h06);
    bd_write(10'h007, 8'h07);
    eb_header(24'h000004);
    sbq.push_back(4'h0); sbq.push_back(4'h4);
    sbq.push_back(4'h0); sbq.push_back(4'h5);
    sbq.push_back(4'h0); sbq.push_back(4'h6);
    sbq.push_back(4'h0); sbq.push_back(4'h7);
    word = '0;
    for (int k = 0; k < 8; k++) begin
      logic [3:0] e;
      @(negedge clk);
      word = {word[27:0], dq};
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL eb_read: queue empty, got %h", dq);
      end else begin
        e = sbq.pop_front();
        check("eb_read.nib", 32'(dq), 32'(e));
      end
    end
    check("eb_read.word", word, 32'h04050607);
    end_frame();

    // Address wrap at top of array, then reset mid-read
    bd_write(10'h3FF, 8'hA5);
    bd_write(10'h000, 8'h3C);
    bd_write(10'h001, 8'h00);
    eb_header(24'h0003FF);
    sbq.push_back(4'hA); sbq.push_back(4'h5);
    sbq.push_back(4'h3); sbq.push_back(4'hC);
    sb_drain("eb_wrap", 4);
    RESET = 1'b1;
    @(negedge clk);
    RESET = 1'b0;
    check("rst_mid.dq", 32'(dq), 32'hF);
    check_flags("rst_mid", 1'b0, 1'b0, 1'b0);
    send_byte(8'h06);
    end_frame();
    check_flags("sync_ignore", 1'b0, 1'b0, 1'b0);
    send_byte(8'h06);
    end_frame();
    check_flags("wren_after_sync", 1'b0, 1'b1, 1'b0);

    // RDID: ID on DQ1 after 32 clocks, repeating; other lines released
    send_byte(8'hAB);
    for (int i = 0; i < 24; i++) send_bit(1'b0);
    release_bus();
    for (int r = 0; r < 2; r++) begin
      logic [7:0] idv;
      idv = ID;
      for (int i = 7; i >= 0; i--) sbq.push_back({2'b11, idv[i], 1'b1});
    end
    sb_drain("rdid", 16);
    end_frame();
    check_flags("rdid_end", 1'b0, 1'b1, 1'b0);

    // EB with quad disabled: bus stays released for the rest of the frame
    send_byte(8'hEB);
    release_bus();
    for (int i = 0; i < 16; i++) sbq.push_back(4'hF);
    sb_drain("eb_qe0_bus", 16);
    end_frame();
    check_flags("eb_qe0_end", 1'b0, 1'b1, 1'b1);
    send_byte(8'h06);
    end_frame();
    check_flags("wren_clr2", 1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
